// File: rtl/wishbone_decoder_pkg.sv
// Shared types and constants for the Wishbone address decoder slice.
package wishbone_decoder_pkg;

    localparam int unsigned WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } dec_state_t;

    // Subordinate index width; a single subordinate still needs a 1-bit select.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wishbone_timeout_counter.sv
// Watchdog counter for the decoder: counts enabled cycles, raises terminal after TERMINAL of them.
module wishbone_timeout_counter
    import wishbone_decoder_pkg::*;
#(
    parameter int unsigned TERMINAL = 255
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned LAST  = (TERMINAL > 0) ? TERMINAL - 1 : 0;
    localparam int unsigned CNT_W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    // terminal is high during the TERMINAL-th enabled cycle, so the caller can still let an ack win.
    always_comb begin
        terminal = (count_q == CNT_W'(LAST));
        count_d  = count_q;
        if (clear)
            count_d = '0;
        else if (enable && !terminal)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/wishbone_decoder.sv
// Wishbone 1-to-NUM_SUBS address decoder with error termination for unmapped addresses.
// Define WB_DECODER_TIMEOUT_EN to add a watchdog that aborts BUSY after TIMEOUT_CYCLES without ack.
module wishbone_decoder
    import wishbone_decoder_pkg::*;
#(
    parameter int unsigned NUM_SUBS       = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int unsigned REGION_BITS    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [31:0]              ADR_I,
    input  logic [31:0]              DAT_I,
    input  logic [WB_SEL_W-1:0]      SEL_I,
    input  logic                     WE_I,
    input  logic                     STB_I,
    input  logic                     CYC_I,
    output logic [31:0]              DAT_O,
    output logic                     ACK_O,
    output logic                     ERR_O,
    output logic [31:0]              S_ADR_O,
    output logic [31:0]              S_DAT_O,
    output logic [WB_SEL_W-1:0]      S_SEL_O,
    output logic                     S_WE_O,
    output logic [NUM_SUBS-1:0]      S_STB_O,
    output logic [NUM_SUBS-1:0]      S_CYC_O,
    input  logic [NUM_SUBS*32-1:0]   S_DAT_I,
    input  logic [NUM_SUBS-1:0]      S_ACK_I
);

    localparam int unsigned IDX_W  = idx_width(NUM_SUBS);
    // 33-bit window bounds so a window ending at 4 GiB does not wrap to zero.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'(NUM_SUBS) << REGION_BITS);

    dec_state_t       state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;

    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             sel_ack;
    logic [31:0]      sel_dat;
    logic             timeout;

    always_comb begin
        hit = ({1'b0, ADR_I} >= WIN_LO) && ({1'b0, ADR_I} < WIN_HI);
        idx = IDX_W'((ADR_I - BASE_ADDR) >> REGION_BITS);
    end

    // Only the latched subordinate can ack or return data; all others are masked here.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int unsigned i = 0; i < NUM_SUBS; i++) begin
            if (IDX_W'(i) == sel_q) begin
                sel_ack = S_ACK_I[i];
                sel_dat = S_DAT_I[i*32 +: 32];
            end
        end
    end

`ifdef WB_DECODER_TIMEOUT_EN
    logic wd_terminal;

    wishbone_timeout_counter #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK      (CLK),
        .nRST     (nRST),
        .clear    (state_q != BUSY),
        .enable   ((state_q == BUSY) && !sel_ack),
        .terminal (wd_terminal)
    );

    always_comb timeout = (state_q == BUSY) && wd_terminal && !sel_ack;
`else
    logic unused_timeout_cfg;

    always_comb begin
        timeout            = 1'b0;
        unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    end
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (STB_I && CYC_I) begin
                    if (hit) begin
                        state_d = BUSY;
                        sel_d   = idx;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            BUSY: begin
                if (!CYC_I || sel_ack)
                    state_d = IDLE;
                else if (timeout)
                    state_d = ERR;
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Everything is quiet outside BUSY/ERR; BUSY passes the manager through to the latched target.
    always_comb begin
        DAT_O   = '0;
        ACK_O   = 1'b0;
        ERR_O   = 1'b0;
        S_ADR_O = '0;
        S_DAT_O = '0;
        S_SEL_O = '0;
        S_WE_O  = 1'b0;
        S_STB_O = '0;
        S_CYC_O = '0;
        if (state_q == BUSY) begin
            S_ADR_O = ADR_I;
            S_DAT_O = DAT_I;
            S_SEL_O = SEL_I;
            S_WE_O  = WE_I;
            DAT_O   = sel_dat;
            ACK_O   = sel_ack && CYC_I;
            for (int unsigned i = 0; i < NUM_SUBS; i++) begin
                if (IDX_W'(i) == sel_q) begin
                    S_STB_O[i] = STB_I;
                    S_CYC_O[i] = CYC_I;
                end
            end
        end else if (state_q == ERR) begin
            ERR_O = 1'b1;
        end
    end

endmodule

// File: tb/tb_wishbone_decoder.sv
// Directed self-checking bench for wishbone_decoder (4 subordinates, 64 KiB regions at 0x3000_0000).
module tb_wishbone_decoder;

    localparam int unsigned NS = 4;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [31:0]       ADR_I, DAT_I;
    logic [3:0]        SEL_I;
    logic              WE_I, STB_I, CYC_I;
    logic [31:0]       DAT_O;
    logic              ACK_O, ERR_O;
    logic [31:0]       S_ADR_O, S_DAT_O;
    logic [3:0]        S_SEL_O;
    logic              S_WE_O;
    logic [NS-1:0]     S_STB_O, S_CYC_O;
    logic [NS*32-1:0]  S_DAT_I;
    logic [NS-1:0]     S_ACK_I;

    int checks   = 0;
    int failures = 0;

    wishbone_decoder #(
        .NUM_SUBS       (NS),
        .BASE_ADDR      (32'h3000_0000),
        .REGION_BITS    (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .ADR_I   (ADR_I),
        .DAT_I   (DAT_I),
        .SEL_I   (SEL_I),
        .WE_I    (WE_I),
        .STB_I   (STB_I),
        .CYC_I   (CYC_I),
        .DAT_O   (DAT_O),
        .ACK_O   (ACK_O),
        .ERR_O   (ERR_O),
        .S_ADR_O (S_ADR_O),
        .S_DAT_O (S_DAT_O),
        .S_SEL_O (S_SEL_O),
        .S_WE_O  (S_WE_O),
        .S_STB_O (S_STB_O),
        .S_CYC_O (S_CYC_O),
        .S_DAT_I (S_DAT_I),
        .S_ACK_I (S_ACK_I)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_bus();
        ADR_I   = '0;
        DAT_I   = '0;
        SEL_I   = '0;
        WE_I    = 1'b0;
        STB_I   = 1'b0;
        CYC_I   = 1'b0;
        S_ACK_I = '0;
    endtask

    task automatic req(input logic [31:0] adr, input logic we, input logic [31:0] dat);
        ADR_I = adr;
        DAT_I = dat;
        SEL_I = 4'hF;
        WE_I  = we;
        STB_I = 1'b1;
        CYC_I = 1'b1;
    endtask

    logic [31:0] bad_adr [2];

    initial begin
        bad_adr[0] = 32'h3004_0000;
        bad_adr[1] = 32'h2FFF_FFFC;
        S_DAT_I = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};

        // Reset with a live-looking request and acks present: everything must stay quiet.
        nRST = 1'b0;
        idle_bus();
        req(32'h3001_0000, 1'b1, 32'hCAFE_F00D);
        S_ACK_I = '1;
        tick();
        tick();
        chk("reset_ack", 32'(ACK_O), 32'h0);
        chk("reset_err", 32'(ERR_O), 32'h0);
        chk("reset_stb", 32'(S_STB_O), 32'h0);
        chk("reset_cyc", 32'(S_CYC_O), 32'h0);
        chk("reset_dat", DAT_O, 32'h0);
        chk("reset_adr", S_ADR_O, 32'h0);
        idle_bus();
        tick();
        nRST = 1'b1;
        tick();

        // Read hit on sub1, ack two cycles after the strobe appears.
        req(32'h3001_0004, 1'b0, 32'h0);
        #1 chk("rd_req_stb", 32'(S_STB_O), 32'h0);
        tick();
        chk("rd_stb", 32'(S_STB_O), 32'h2);
        chk("rd_cyc", 32'(S_CYC_O), 32'h2);
        chk("rd_wait1", 32'(ACK_O), 32'h0);
        tick();
        chk("rd_wait2", 32'(ACK_O), 32'h0);
        tick();
        S_ACK_I = 4'b0010;
        #1 chk("rd_ack", 32'(ACK_O), 32'h1);
        chk("rd_dat", DAT_O, 32'hDEAD_BEEF);
        tick();
        idle_bus();
        #1 chk("rd_done_stb", 32'(S_STB_O), 32'h0);
        chk("rd_done_ack", 32'(ACK_O), 32'h0);

        // Write hit on sub3.
        tick();
        req(32'h3003_0010, 1'b1, 32'h1234_5678);
        #1 chk("wr_req_stb", 32'(S_STB_O), 32'h0);
        tick();
        chk("wr_stb", 32'(S_STB_O), 32'h8);
        chk("wr_adr", S_ADR_O, 32'h3003_0010);
        chk("wr_dat", S_DAT_O, 32'h1234_5678);
        chk("wr_sel", 32'(S_SEL_O), 32'hF);
        chk("wr_we", 32'(S_WE_O), 32'h1);
        chk("wr_wait", 32'(ACK_O), 32'h0);
        tick();
        S_ACK_I = 4'b1000;
        #1 chk("wr_ack", 32'(ACK_O), 32'h1);
        chk("wr_err", 32'(ERR_O), 32'h0);
        tick();
        idle_bus();
        #1 chk("wr_done_stb", 32'(S_STB_O), 32'h0);

        // Unmapped addresses above and below the window; manager drops CYC during the error cycle.
        for (int i = 0; i < 2; i++) begin
            tick();
            req(bad_adr[i], 1'b0, 32'h0);
            #1 chk($sformatf("err%0d_req", i), 32'(ERR_O), 32'h0);
            tick();
            idle_bus();
            #1 chk($sformatf("err%0d_pulse", i), 32'(ERR_O), 32'h1);
            chk($sformatf("err%0d_ack", i), 32'(ACK_O), 32'h0);
            chk($sformatf("err%0d_stb", i), 32'(S_STB_O), 32'h0);
            chk($sformatf("err%0d_dat", i), DAT_O, 32'h0);
            tick();
            chk($sformatf("err%0d_end", i), 32'(ERR_O), 32'h0);
        end

        // Stray ack from sub0 while sub2 is selected.
        tick();
        req(32'h3002_0000, 1'b0, 32'h0);
        tick();
        S_ACK_I = 4'b0001;
        #1 chk("stray_stb", 32'(S_STB_O), 32'h4);
        chk("stray_ack1", 32'(ACK_O), 32'h0);
        tick();
        chk("stray_ack2", 32'(ACK_O), 32'h0);
        tick();
        S_ACK_I = 4'b0100;
        #1 chk("stray_ack", 32'(ACK_O), 32'h1);
        chk("stray_dat", DAT_O, 32'h2222_2222);
        tick();
        idle_bus();
        #1 chk("stray_done", 32'(S_STB_O), 32'h0);

        // Abort: CYC drops in BUSY together with a subordinate ack.
        tick();
        req(32'h3000_0008, 1'b0, 32'h0);
        tick();
        chk("abort_stb", 32'(S_STB_O), 32'h1);
        tick();
        CYC_I   = 1'b0;
        S_ACK_I = 4'b0001;
        #1 chk("abort_ack", 32'(ACK_O), 32'h0);
        chk("abort_err", 32'(ERR_O), 32'h0);
        tick();
        CYC_I   = 1'b1;
        STB_I   = 1'b0;
        S_ACK_I = '0;
        #1 chk("abort_idle", 32'(S_CYC_O), 32'h0);
        chk("abort_err2", 32'(ERR_O), 32'h0);
        tick();
        idle_bus();

        // Reset pulsed mid-transaction, then a normal request.
        tick();
        req(32'h3001_0000, 1'b0, 32'h0);
        tick();
        chk("rst_busy_stb", 32'(S_STB_O), 32'h2);
        S_ACK_I = 4'b0010;
        nRST    = 1'b0;
        #1 chk("rst_stb", 32'(S_STB_O), 32'h0);
        chk("rst_ack", 32'(ACK_O), 32'h0);
        chk("rst_adr", S_ADR_O, 32'h0);
        idle_bus();
        tick();
        nRST = 1'b1;
        tick();
        req(32'h3001_0000, 1'b0, 32'h0);
        tick();
        S_ACK_I = 4'b0010;
        #1 chk("post_rst_stb", 32'(S_STB_O), 32'h2);
        chk("post_rst_ack", 32'(ACK_O), 32'h1);
        chk("post_rst_dat", DAT_O, 32'hDEAD_BEEF);
        tick();
        idle_bus();

`ifdef WB_DECODER_TIMEOUT_EN
        // sub0 never acks: strobed for 8 BUSY cycles, then one ERR cycle.
        tick();
        req(32'h3000_0000, 1'b0, 32'h0);
        repeat (8) tick();
        chk("wd_stb8", 32'(S_STB_O), 32'h1);
        chk("wd_err8", 32'(ERR_O), 32'h0);
        tick();
        idle_bus();
        #1 chk("wd_stb9", 32'(S_STB_O), 32'h0);
        chk("wd_err9", 32'(ERR_O), 32'h1);
        chk("wd_ack9", 32'(ACK_O), 32'h0);
        tick();
        chk("wd_err10", 32'(ERR_O), 32'h0);

        // Ack lands on the terminal cycle: it wins.
        tick();
        req(32'h3000_0000, 1'b0, 32'h0);
        repeat (7) tick();
        chk("wd_ack7", 32'(ACK_O), 32'h0);
        tick();
        S_ACK_I = 4'b0001;
        #1 chk("wd_ack8", 32'(ACK_O), 32'h1);
        chk("wd_noerr8", 32'(ERR_O), 32'h0);
        tick();
        idle_bus();
        #1 chk("wd_noerr9", 32'(ERR_O), 32'h0);
        chk("wd_stb_after", 32'(S_STB_O), 32'h0);
`else
        // Without the watchdog BUSY waits as long as it takes.
        tick();
        req(32'h3000_0000, 1'b0, 32'h0);
        repeat (20) tick();
        chk("nowd_stb", 32'(S_STB_O), 32'h1);
        chk("nowd_err", 32'(ERR_O), 32'h0);
        S_ACK_I = 4'b0001;
        #1 chk("nowd_ack", 32'(ACK_O), 32'h1);
        tick();
        idle_bus();
        #1 chk("nowd_done", 32'(S_STB_O), 32'h0);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
